// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: controller FSM encoding, busy-timeout default,
// ALU control codes and a saturating counter helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } pipe_state_e;

  localparam int BUSY_TMO_DEFAULT = 64;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_ctrl_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
    return (en && (val != 16'hFFFF)) ? val + 16'd1 : val;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard comparator: a load in EX writes a register that ID reads.
module hazard_det (
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       re1_i,
  input  logic       re2_i,
  input  logic [4:0] waddr_i,
  input  logic       mem_re_i,
  output logic       hazard_o
);

  // x0 is never a real destination, so a load into it cannot create a hazard
  assign hazard_o = mem_re_i && (waddr_i != 5'd0) &&
                    ((re1_i && (rs1_i == waddr_i)) || (re2_i && (rs2_i == waddr_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: load-use bubbles, jump flushes, multi-cycle EX holds
// with a busy timeout, and saturating stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BUSY_TMO = BUSY_TMO_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_reg1_raddr_i,
  input  logic [4:0]  id_reg2_raddr_i,
  input  logic        id_reg1_RE_i,
  input  logic        id_reg2_RE_i,
  input  logic [4:0]  ex_reg_waddr_i,
  input  logic        ex_mem_re_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        ex_start_i,
  input  logic        ex_done_i,
  output logic        ctrl_pc_hold_o,
  output logic        ctrl_if_id_hold_o,
  output logic        ctrl_id_ex_hold_o,
  output logic        ctrl_if_id_flush_o,
  output logic        ctrl_id_ex_flush_o,
  output logic        ctrl_jump_o,
  output logic [31:0] ctrl_jump_addr_o,
  output logic        ctrl_err_o,
  output logic [15:0] ctrl_stall_cnt_o,
  output logic [15:0] ctrl_flush_cnt_o
);

  localparam int CNT_W = $clog2(BUSY_TMO + 1);

  pipe_state_e      state_q, state_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             err_q, err_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic [15:0]      flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, jump;

  hazard_det u_hazard_det (
    .rs1_i    (id_reg1_raddr_i),
    .rs2_i    (id_reg2_raddr_i),
    .re1_i    (id_reg1_RE_i),
    .re2_i    (id_reg2_RE_i),
    .waddr_i  (ex_reg_waddr_i),
    .mem_re_i (ex_mem_re_i),
    .hazard_o (hazard)
  );

  always_comb begin
    state_d     = state_q;
    busy_cnt_d  = busy_cnt_q;
    err_d       = err_q;
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    id_ex_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    jump        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ex_jump_i) begin
          jump        = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = ST_FLUSH;
        end else if (ex_start_i) begin
          // a single-cycle op (start and done together) needs no stall
          if (!ex_done_i) begin
            state_d    = ST_BUSY;
            busy_cnt_d = '0;
          end
        end else if (hazard) begin
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      ST_FLUSH: begin
        // the synchronous instruction ROM still presents the pre-jump word
        if_id_flush = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_BUSY: begin
        if (busy_cnt_q == CNT_W'(BUSY_TMO)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (ex_done_i) begin
          state_d = ST_IDLE;
        end else begin
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
          id_ex_hold = 1'b1;
          busy_cnt_d = busy_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs are forced low while reset is held, whatever the inputs do
  assign ctrl_pc_hold_o     = rst_n & pc_hold;
  assign ctrl_if_id_hold_o  = rst_n & if_id_hold;
  assign ctrl_id_ex_hold_o  = rst_n & id_ex_hold;
  assign ctrl_if_id_flush_o = rst_n & if_id_flush;
  assign ctrl_id_ex_flush_o = rst_n & id_ex_flush;
  assign ctrl_jump_o        = rst_n & jump;
  assign ctrl_jump_addr_o   = ctrl_jump_o ? ex_jump_addr_i : 32'd0;

  assign stall_cnt_d = sat_inc16(stall_cnt_q, ctrl_pc_hold_o);
  assign flush_cnt_d = sat_inc16(flush_cnt_q, ctrl_if_id_flush_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ctrl_err_o       = err_q;
  assign ctrl_stall_cnt_o = stall_cnt_q;
  assign ctrl_flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter BUSY_TMO, default 64, giving the maximum number of cycles in BUSY before the timeout error is raised.
REQ-002 SHALL have clk  input  1  as the single clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n  input  1  as the reset; asynchronous, active-low.
REQ-004 SHALL have id_reg1_raddr_i / id_reg2_raddr_i  input  5 each  as the ID source register addresses.
REQ-005 SHALL have id_reg1_RE_i / id_reg2_RE_i  input  1 each  as the ID source read enables.
REQ-006 SHALL have ex_reg_waddr_i  input  5  as the EX destination register.
REQ-007 SHALL have ex_mem_re_i  input  1  to indicate that the EX instruction is a load.
REQ-008 SHALL have ex_jump_i  input  1  and ex_jump_addr_i  input  32  for a taken branch/jump resolved in EX.
REQ-009 SHALL have ex_start_i  input  1  to indicate that a multi-cycle EX op starts this cycle.
REQ-010 SHALL have ex_done_i  input  1  to indicate that the multi-cycle op completes this cycle.
REQ-011 SHALL have outputs ctrl_pc_hold_o, ctrl_if_id_hold_o, ctrl_id_ex_hold_o, ctrl_if_id_flush_o, ctrl_id_ex_flush_o, each  output  1.
REQ-012 SHALL have ctrl_jump_o  output  1  and ctrl_jump_addr_o  output  32  as the PC redirect.
REQ-013 SHALL have ctrl_err_o  output  1  as the sticky busy-timeout flag.
REQ-014 SHALL have ctrl_stall_cnt_o  output  16  and ctrl_flush_cnt_o  output  16  as saturating performance counters.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and FLUSH.
REQ-016 Load-use hazard SHALL be: ex_mem_re_i & ex_reg_waddr_i!=0 & ((id_reg1_RE_i & rs1==waddr) | (id_reg2_RE_i & rs2==waddr)).
REQ-017 In IDLE with a load-use hazard and no jump, it SHALL assert pc_hold, if_id_hold and id_ex_flush in the same cycle (one bubble), and SHALL stay in IDLE.
REQ-018 In IDLE with ex_jump_i=1, it SHALL assert ctrl_jump_o, drive ctrl_jump_addr_o=ex_jump_addr_i, and assert if_id_flush and id_ex_flush in the same cycle; next state SHALL be FLUSH.
REQ-019 In FLUSH it SHALL assert if_id_flush for exactly one cycle, covering the stale synchronous-ROM word; next state SHALL be IDLE unconditionally; hazard detection SHALL be suppressed.
REQ-020 In IDLE with ex_start_i=1 and ex_done_i=0, it SHALL go to BUSY; with ex_start_i=ex_done_i=1 it SHALL stay in IDLE with no hold.
REQ-021 In BUSY it SHALL assert pc_hold, if_id_hold and id_ex_hold while ex_done_i=0; the cycle ex_done_i=1 SHALL deassert all holds and return to IDLE.
REQ-022 Priority in IDLE SHALL be: jump > start > load-use; on a jump, start and load-use SHALL be ignored.
REQ-023 In BUSY, ex_jump_i and load-use SHALL be ignored.
REQ-024 A BUSY cycle counter SHALL clear on BUSY entry; when it reaches BUSY_TMO, ctrl_err_o SHALL be set, the FSM SHALL force IDLE and release holds; ctrl_err_o SHALL clear only on reset.
REQ-025 ctrl_stall_cnt_o SHALL increment on every cycle with pc_hold=1, and ctrl_flush_cnt_o on every cycle with if_id_flush=1; both SHALL saturate at 16'hFFFF without wrap.
REQ-026 ctrl_jump_addr_o SHALL be 0 when ctrl_jump_o=0.
REQ-027 All hold/flush/jump outputs SHALL be combinational from the state and current inputs; counters and err SHALL be registered.

Reset
REQ-028 On rst_n=0 it SHALL immediately set state=IDLE, busy counter=0, ctrl_err_o=0 and both perf counters=0.
REQ-029 While rst_n=0, all hold/flush/jump outputs SHALL be 0 and ctrl_jump_addr_o=0.
REQ-030 Reset asserted in BUSY or FLUSH SHALL abandon the operation; the first cycle after release SHALL be IDLE.

Structure
REQ-031 FSM state encoding and the default for BUSY_TMO SHALL live in the shared pipeline package, alongside the ALUctrl codes.
REQ-032 The load-use comparator SHALL be one sub-module, hazard_det (pure combinational); all else SHALL be inline.

Verification
REQ-033 Load x5 in EX with ID reading rs1=x5, RE1=1 -> one cycle pc_hold=if_id_hold=id_ex_flush=1, stall_cnt=1; with waddr=0 -> no stall.
REQ-034 ex_jump_i=1, addr=0x0000_0100 -> that cycle jump_o=1, addr=0x100, both flushes=1; next cycle only if_id_flush=1; then IDLE; flush_cnt=2.
REQ-035 Jump and load-use in the same cycle -> jump behaviour only, pc_hold=0.
REQ-036 ex_start_i, then ex_done_i after 5 cycles -> holds asserted for 5 cycles, released on the done cycle; start and done together -> no hold.
REQ-037 ex_start_i with no done, BUSY_TMO=8 -> holds for 8 cycles, then err=1 and IDLE; err stays 1 until rst_n=0.
REQ-038 rst_n pulsed low mid-BUSY -> all outputs 0 asynchronously, counters 0, IDLE after release.
